// File: rtl/e_mdu.sv
// E-stage multiply/divide unit: owns HI/LO, sequences mult/div over a fixed
// number of busy cycles and serves mfhi/mflo/mthi/mtlo in a single cycle.
module e_mdu #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  mdu_c,
    input  logic [31:0] data1,
    input  logic [31:0] data2,
    output logic        start,
    output logic        busy,
    output logic [31:0] mdu_out
);

    typedef enum logic [3:0] {
        OP_NONE  = 4'd0,
        OP_MULT  = 4'd1,
        OP_MULTU = 4'd2,
        OP_DIV   = 4'd3,
        OP_DIVU  = 4'd4,
        OP_MFHI  = 4'd5,
        OP_MFLO  = 4'd6,
        OP_MTHI  = 4'd7,
        OP_MTLO  = 4'd8
    } op_e;

    typedef enum logic {S_IDLE, S_RUN} state_e;

    localparam int MAX_N = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    // Four bits cover up to 15 cycles; longer latencies grow by one bit per doubling.
    localparam int CNT_W = (MAX_N < 16) ? 4 : $clog2(MAX_N + 1);
    localparam logic [CNT_W-1:0] MULT_CNT = CNT_W'(MULT_CYCLES);
    localparam logic [CNT_W-1:0] DIV_CNT  = CNT_W'(DIV_CYCLES);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(1);

    state_e           state, next_state;
    logic [CNT_W-1:0] cnt;
    logic [31:0]      hi, lo;
    logic [31:0]      op_a, op_b;
    logic [3:0]       op_r;
    logic             is_md;

    logic [63:0] prod_s, prod_u;
    logic        signed_div, a_neg, b_neg;
    logic [31:0] dvd, dvs, quo_mag, rem_mag, quo, rem;

    assign is_md = (mdu_c >= OP_MULT) && (mdu_c <= OP_DIVU);

    // Results are formed from the latched operands only, never from data1/data2.
    assign prod_s = $signed({{32{op_a[31]}}, op_a}) * $signed({{32{op_b[31]}}, op_b});
    assign prod_u = {32'b0, op_a} * {32'b0, op_b};

    // Signed divide runs on magnitudes, then fixes signs: quotient truncates
    // toward zero and the remainder takes the dividend's sign.
    assign signed_div = (op_r == OP_DIV);
    assign a_neg      = signed_div && op_a[31];
    assign b_neg      = signed_div && op_b[31];
    assign dvd        = a_neg ? -op_a : op_a;
    assign dvs        = b_neg ? -op_b : op_b;
    assign quo_mag    = (dvs == 32'd0) ? 32'd0 : dvd / dvs;
    assign rem_mag    = (dvs == 32'd0) ? 32'd0 : dvd % dvs;
    assign quo        = (a_neg ^ b_neg) ? -quo_mag : quo_mag;
    assign rem        = a_neg ? -rem_mag : rem_mag;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= next_state;
    end

    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned and infers a latch.
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE: if (is_md)            next_state = S_RUN;
            S_RUN:  if (cnt == LAST_CNT)  next_state = S_IDLE;
            default:                      next_state = S_IDLE;
        endcase
    end

    always_comb begin
        busy    = (state == S_RUN);
        start   = is_md && (state == S_IDLE);
        mdu_out = 32'd0;
        if (mdu_c == OP_MFHI)      mdu_out = hi;
        else if (mdu_c == OP_MFLO) mdu_out = lo;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hi   <= 32'd0;
            lo   <= 32'd0;
            cnt  <= '0;
            op_a <= 32'd0;
            op_b <= 32'd0;
            op_r <= OP_NONE;
        end else if (start) begin
            op_a <= data1;
            op_b <= data2;
            op_r <= mdu_c;
            cnt  <= (mdu_c <= OP_MULTU) ? MULT_CNT : DIV_CNT;
        end else if (busy) begin
            cnt <= cnt - LAST_CNT;
            if (cnt == LAST_CNT) begin
                case (op_r)
                    OP_MULT:          {hi, lo} <= prod_s;
                    OP_MULTU:         {hi, lo} <= prod_u;
                    OP_DIV, OP_DIVU:  if (op_b != 32'd0) {hi, lo} <= {rem, quo};
                    default: ;
                endcase
            end
        end else if (mdu_c == OP_MTHI) begin
            hi <= data1;
        end else if (mdu_c == OP_MTLO) begin
            lo <= data1;
        end
    end

endmodule

// File: tb/tb_e_mdu.sv
// Self-checking bench for e_mdu: directed vector table, multi-cycle corner
// sequences and randomized traffic checked against an arithmetic HI/LO model.
module tb_e_mdu;

    localparam int MC = 5;
    localparam int DC = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  mdu_c;
    logic [31:0] data1, data2;
    logic        start, busy;
    logic [31:0] mdu_out;

    e_mdu #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk     (clk),
        .reset   (reset),
        .mdu_c   (mdu_c),
        .data1   (data1),
        .data2   (data2),
        .start   (start),
        .busy    (busy),
        .mdu_out (mdu_out)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model: architectural HI/LO, cycles left on the running op and
    // the result that op will deliver.
    logic [31:0] m_hi, m_lo, p_hi, p_lo;
    logic        p_valid;
    int          m_left;

    logic [31:0] o;
    logic        bz, st;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model_launch(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        longint      sa, sb, p;
        logic [63:0] u;
        p_valid = 1'b1;
        m_left  = (op <= 4'd2) ? MC : DC;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (op)
            4'd1: begin p = sa * sb; {p_hi, p_lo} = p; end
            4'd2: begin u = {32'b0, a} * {32'b0, b}; {p_hi, p_lo} = u; end
            4'd3: if (b == 32'd0) p_valid = 1'b0;
                  else begin p_lo = 32'(sa / sb); p_hi = 32'(sa % sb); end
            default: if (b == 32'd0) p_valid = 1'b0;
                  else begin p_lo = a / b; p_hi = a % b; end
        endcase
    endtask

    // One clock cycle: apply inputs, check outputs against the model, advance the model.
    task automatic step(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic r, output logic [31:0] out_v, output logic busy_v,
                        output logic start_v);
        logic [31:0] e_out;
        logic        e_start;
        mdu_c = op; data1 = a; data2 = b; reset = r;
        @(negedge clk);
        out_v   = mdu_out;
        busy_v  = busy;
        start_v = start;
        e_out   = (op == 4'd5) ? m_hi : (op == 4'd6) ? m_lo : 32'd0;
        e_start = (op >= 4'd1) && (op <= 4'd4) && (m_left == 0);
        check("start", 32'(start_v), 32'(e_start));
        check("busy", 32'(busy_v), 32'(m_left > 0));
        check("mdu_out", out_v, e_out);
        @(posedge clk);
        if (r) begin
            m_hi = 32'd0; m_lo = 32'd0; m_left = 0; p_valid = 1'b0;
        end else if (m_left > 0) begin
            m_left--;
            if (m_left == 0 && p_valid) begin m_hi = p_hi; m_lo = p_lo; end
        end else if (op >= 4'd1 && op <= 4'd4) begin
            model_launch(op, a, b);
        end else if (op == 4'd7) begin
            m_hi = a;
        end else if (op == 4'd8) begin
            m_lo = a;
        end
        #1;
    endtask

    // Idle until the model says the running op is done; returns busy cycles seen.
    task automatic wait_done(output int nb);
        nb = 0;
        for (int k = 0; k < 64 && m_left > 0; k++) begin
            step(4'd0, 32'd0, 32'd0, 1'b0, o, bz, st);
            nb += int'(bz);
        end
        check("done_timeout", 32'(m_left), 32'd0);
    endtask

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a, b, hi, lo;
        int          n;
    } vec_t;

    vec_t tbl[7];
    int   nb;

    initial begin
        tbl[0] = '{4'd1, 32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1, MC};
        tbl[1] = '{4'd2, 32'hFFFFFFFF, 32'h00000002, 32'h00000001, 32'hFFFFFFFE, MC};
        tbl[2] = '{4'd3, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, DC};
        tbl[3] = '{4'd4, 32'h00000007, 32'h00000002, 32'h00000001, 32'h00000003, DC};
        tbl[4] = '{4'd3, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, DC};
        tbl[5] = '{4'd3, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, DC};
        tbl[6] = '{4'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, MC};

        reset = 1'b1; mdu_c = 4'd0; data1 = 32'd0; data2 = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        m_hi = 32'd0; m_lo = 32'd0; m_left = 0; p_valid = 1'b0;

        // Reset state
        step(4'd5, 32'd0, 32'd0, 1'b0, o, bz, st);
        check("reset_hi", o, 32'd0);
        check("reset_busy", 32'(bz), 32'd0);
        step(4'd6, 32'd0, 32'd0, 1'b0, o, bz, st);
        check("reset_lo", o, 32'd0);

        // Directed vectors
        for (int i = 0; i < 7; i++) begin
            step(tbl[i].op, tbl[i].a, tbl[i].b, 1'b0, o, bz, st);
            check($sformatf("vec%0d_start", i), 32'(st), 32'd1);
            wait_done(nb);
            check($sformatf("vec%0d_busy_cycles", i), nb, tbl[i].n);
            step(4'd5, 32'd0, 32'd0, 1'b0, o, bz, st);
            check($sformatf("vec%0d_hi", i), o, tbl[i].hi);
            step(4'd6, 32'd0, 32'd0, 1'b0, o, bz, st);
            check($sformatf("vec%0d_lo", i), o, tbl[i].lo);
        end

        // mthi during a running mult is ignored; mtlo while idle takes effect
        step(4'd1, 32'd2, 32'd3, 1'b0, o, bz, st);
        step(4'd7, 32'h12345678, 32'd0, 1'b0, o, bz, st);
        step(4'd1, 32'd9, 32'd9, 1'b0, o, bz, st);
        check("relaunch_blocked", 32'(st), 32'd0);
        wait_done(nb);
        step(4'd5, 32'd0, 32'd0, 1'b0, o, bz, st);
        check("mthi_ignored_hi", o, 32'd0);
        step(4'd6, 32'd0, 32'd0, 1'b0, o, bz, st);
        check("mult23_lo", o, 32'd6);
        step(4'd8, 32'hAABBCCDD, 32'd0, 1'b0, o, bz, st);
        step(4'd6, 32'd0, 32'd0, 1'b0, o, bz, st);
        check("mtlo_lo", o, 32'hAABBCCDD);

        // Divide by zero keeps HI/LO
        step(4'd7, 32'h11, 32'd0, 1'b0, o, bz, st);
        step(4'd8, 32'h22, 32'd0, 1'b0, o, bz, st);
        step(4'd3, 32'd5, 32'd0, 1'b0, o, bz, st);
        wait_done(nb);
        check("div0_busy_cycles", nb, DC);
        step(4'd5, 32'd0, 32'd0, 1'b0, o, bz, st);
        check("div0_hi", o, 32'h11);
        step(4'd6, 32'd0, 32'd0, 1'b0, o, bz, st);
        check("div0_lo", o, 32'h22);

        // Back-to-back: mult accepted in the first idle cycle after a divide
        step(4'd4, 32'd9, 32'd0, 1'b0, o, bz, st);
        wait_done(nb);
        step(4'd1, 32'd4, 32'd5, 1'b0, o, bz, st);
        check("b2b_start", 32'(st), 32'd1);
        wait_done(nb);
        check("b2b_busy_cycles", nb, MC);
        step(4'd6, 32'd0, 32'd0, 1'b0, o, bz, st);
        check("b2b_lo", o, 32'd20);

        // Reset in the third busy cycle of a divide abandons it
        step(4'd7, 32'hCAFEF00D, 32'd0, 1'b0, o, bz, st);
        step(4'd3, 32'd100, 32'd7, 1'b0, o, bz, st);
        step(4'd0, 32'd0, 32'd0, 1'b0, o, bz, st);
        step(4'd0, 32'd0, 32'd0, 1'b0, o, bz, st);
        step(4'd0, 32'd0, 32'd0, 1'b1, o, bz, st);
        check("rst_run_busy_before", 32'(bz), 32'd1);
        step(4'd5, 32'd0, 32'd0, 1'b0, o, bz, st);
        check("rst_run_busy", 32'(bz), 32'd0);
        check("rst_run_hi", o, 32'd0);
        for (int k = 0; k < DC + 2; k++) step(4'd6, 32'd0, 32'd0, 1'b0, o, bz, st);
        check("rst_run_no_late_lo", o, 32'd0);

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            logic [3:0]  rop;
            logic [31:0] ra, rb;
            logic        rr;
            rr  = ($urandom_range(0, 63) == 0);
            rop = $urandom_range(0, 1) ? 4'($urandom_range(1, 8)) : 4'($urandom_range(0, 15));
            ra  = $urandom;
            case ($urandom_range(0, 7))
                0:       rb = 32'd0;
                1, 2:    rb = 32'($urandom_range(1, 9));
                3:       rb = -32'($urandom_range(1, 9));
                default: rb = $urandom;
            endcase
            step(rop, ra, rb, rr, o, bz, st);
        end
        wait_done(nb);
        step(4'd5, 32'd0, 32'd0, 1'b0, o, bz, st);
        step(4'd6, 32'd0, 32'd0, 1'b0, o, bz, st);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
